load_store_unit: RTL and testbench

- Initiator side of the byte-addressable data-memory port: accepts one load/store request at a time from the core pipeline over a valid/ready handshake.
- Drives the memory address/data/size/write-enable bus and waits out the memory's fixed synchronous read latency.
- Sign- or zero-extends load data and returns a single response (data plus error flag) over a second valid/ready handshake.
- Sits between the execute stage and the data memory.

---
 rtl/load_store_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory initiator between the execute stage and a byte-addressable
// synchronous memory. It accepts one load/store at a time, drives the memory
// bus, waits out the fixed read latency, extends load data and returns a
// single response (data + error flag).
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with resp_error
//   undefined - misaligned accesses go to memory as byte-sequential
//               little-endian accesses, bounded only by ADDR_LIMIT
//
// Every output is driven straight from a register. Memory bus registers are
// zero whenever the FSM is not in WRITE or READ, so ERR/RESP/IDLE never show
// bus activity.

module load_store_unit #(
  parameter int unsigned READ_LATENCY = 2,   // 1..7, fits the 3-bit counter
  parameter int unsigned ADDR_LIMIT   = 256  // memory size in bytes
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] memory_address,
  output logic [31:0] memory_in,
  output logic [1:0]  memory_size,
  output logic        memory_write_enable,
  input  logic [31:0] memory_out
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ERR   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [32:0] LIMIT_C = 33'(ADDR_LIMIT);
  localparam logic [2:0]  LAT_C   = 3'(READ_LATENCY);

  // Number of bytes touched by an access of the given size code.
  function automatic logic [32:0] size_bytes(input logic [1:0] size);
    logic [32:0] n;
    case (size)
      2'b00:   n = 33'd1;
      2'b01:   n = 33'd2;
      default: n = 33'd4;
    endcase
    return n;
  endfunction

  // Sign- or zero-extend raw memory data to 32 bits; words pass unchanged.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [31:0] res;
    case (size)
      2'b00:   res = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
      2'b01:   res = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // State and output registers
  state_t      state_r,      state_s;
  logic [2:0]  cnt_r,        cnt_s;
  logic [1:0]  ld_size_r,    ld_size_s;
  logic        ld_signed_r,  ld_signed_s;
  logic        req_ready_r,  req_ready_s;
  logic        resp_valid_r, resp_valid_s;
  logic [31:0] resp_rdata_r, resp_rdata_s;
  logic        resp_error_r, resp_error_s;
  logic [31:0] mem_addr_r,   mem_addr_s;
  logic [31:0] mem_wdata_r,  mem_wdata_s;
  logic [1:0]  mem_size_r,   mem_size_s;
  logic        mem_we_r,     mem_we_s;

  // Request validation
  logic [32:0] last_byte_s;
  logic        misalign_s;
  logic        req_bad_s;

  // Validate the presented request: illegal size, out-of-range end byte
  // (33-bit sum so a high address cannot wrap) or optional misalignment.
  always_comb begin
    last_byte_s = {1'b0, req_addr} + size_bytes(req_size) - 33'd1;
`ifdef MISALIGN_CHECK_EN
    misalign_s  = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_s  = 1'b0;
`endif
    req_bad_s   = (req_size == 2'b11) || (last_byte_s >= LIMIT_C) || misalign_s;
  end

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    ld_size_s    = ld_size_r;
    ld_signed_s  = ld_signed_r;
    req_ready_s  = req_ready_r;
    resp_valid_s = resp_valid_r;
    resp_rdata_s = resp_rdata_r;
    resp_error_s = resp_error_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    mem_size_s   = mem_size_r;
    mem_we_s     = mem_we_r;

    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          // Accept edge: capture everything needed later, drop ready.
          req_ready_s = 1'b0;
          ld_size_s   = req_size;
          ld_signed_s = req_signed;
          cnt_s       = 3'd0;
          if (req_bad_s) begin
            state_s = ST_ERR;
          end else if (req_write) begin
            state_s     = ST_WRITE;
            mem_addr_s  = req_addr;
            mem_wdata_s = req_wdata;
            mem_size_s  = req_size;
            mem_we_s    = 1'b1;
          end else begin
            state_s     = ST_READ;
            mem_addr_s  = req_addr;
            mem_wdata_s = 32'd0;
            mem_size_s  = req_size;
            mem_we_s    = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        // Single write cycle done; release the bus and report success.
        state_s      = ST_RESP;
        mem_addr_s   = 32'd0;
        mem_wdata_s  = 32'd0;
        mem_size_s   = 2'b00;
        mem_we_s     = 1'b0;
        resp_valid_s = 1'b1;
        resp_rdata_s = 32'd0;
        resp_error_s = 1'b0;
      end

      ST_READ: begin
        // Address has been stable for cnt_r edges; memory_out is valid
        // once the counter reaches the read latency.
        if (cnt_r == LAT_C) begin
          state_s      = ST_RESP;
          mem_addr_s   = 32'd0;
          mem_size_s   = 2'b00;
          resp_valid_s = 1'b1;
          resp_rdata_s = extend_load(memory_out, ld_size_r, ld_signed_r);
          resp_error_s = 1'b0;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end

      ST_ERR: begin
        // Rejected request: no bus activity, error response with zero data.
        state_s      = ST_RESP;
        resp_valid_s = 1'b1;
        resp_rdata_s = 32'd0;
        resp_error_s = 1'b1;
      end

      ST_RESP: begin
        // Hold the response stable until the consumer takes it; ready
        // returns one cycle after the handshake.
        if (resp_ready) begin
          state_s      = ST_IDLE;
          resp_valid_s = 1'b0;
          resp_rdata_s = 32'd0;
          resp_error_s = 1'b0;
          req_ready_s  = 1'b1;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        cnt_s        = 3'd0;
        req_ready_s  = 1'b1;
        resp_valid_s = 1'b0;
        resp_rdata_s = 32'd0;
        resp_error_s = 1'b0;
        mem_addr_s   = 32'd0;
        mem_wdata_s  = 32'd0;
        mem_size_s   = 2'b00;
        mem_we_s     = 1'b0;
      end
    endcase
  end

  // State/output registers with synchronous reset abandoning any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 3'd0;
      ld_size_r    <= 2'b00;
      ld_signed_r  <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_error_r <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_wdata_r  <= 32'd0;
      mem_size_r   <= 2'b00;
      mem_we_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      ld_size_r    <= ld_size_s;
      ld_signed_r  <= ld_signed_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_error_r <= resp_error_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      mem_size_r   <= mem_size_s;
      mem_we_r     <= mem_we_s;
    end
  end

  assign req_ready           = req_ready_r;
  assign resp_valid          = resp_valid_r;
  assign resp_rdata          = resp_rdata_r;
  assign resp_error          = resp_error_r;
  assign memory_address      = mem_addr_r;
  assign memory_in           = mem_wdata_r;
  assign memory_size         = mem_size_r;
  assign memory_write_enable = mem_we_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases plus randomized requests,
// checked against a byte-array reference model of the memory and the
// request rules (range, size, optional alignment, extension, latency).

module tb_load_store_unit;

  localparam int RL    = 2;
  localparam int LIMIT = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] memory_address, memory_in, memory_out;
  logic [1:0]  memory_size;
  logic        memory_write_enable;

  int checks_cnt = 0;
  int errors_cnt = 0;

  load_store_unit #(.READ_LATENCY(RL), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .memory_address(memory_address), .memory_in(memory_in),
    .memory_size(memory_size), .memory_write_enable(memory_write_enable),
    .memory_out(memory_out)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  // ---------------- synchronous memory model (environment) ----------------
  logic [7:0]  mem [0:LIMIT-1];
  logic [31:0] pipe [0:RL-1];
  logic        mem_ready = 1'b0;

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = mem[8'(a + 32'(i))];
    return v;
  endfunction

  // Memory: byte writes on write enable, read data through an RL-deep pipe
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < LIMIT; i++) mem[i] <= 8'd0;
      for (int i = 0; i < RL; i++) pipe[i] <= 32'd0;
      mem_ready <= 1'b1;
    end else begin
      if (memory_write_enable) begin
        for (int i = 0; i < nbytes(memory_size); i++)
          mem[8'(memory_address + 32'(i))] <= memory_in[8*i +: 8];
      end
      pipe[0] <= mem_read(memory_address, memory_size);
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign memory_out = pipe[RL-1];

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:LIMIT-1];

  function automatic logic pred_err(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b11) return 1'b1;
    if (longint'({32'd0, a}) + longint'(nbytes(s)) > longint'(LIMIT)) return 1'b1;
`ifdef MISALIGN_CHECK_EN
    if ((int'(a[1:0]) % nbytes(s)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] pred_load(input logic [1:0] s, input logic sg, input logic [31:0] a);
    longint v;
    int     n;
    n = nbytes(s);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(a + 32'(i))]) << (8*i);
    if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, ":resp_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, ":we"}, 32'(memory_write_enable), 32'd0);
    check_val({tag, ":rdata"}, resp_rdata, 32'd0);
    check_val({tag, ":addr"}, memory_address, 32'd0);
  endtask

  // One full request/response transaction; latency is counted from the
  // accept cycle, so a response seen one edge after accept is latency 2.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input int hold,
                        output logic [31:0] got_d, output logic got_e);
    int          edges, we_cnt, waited;
    logic        exp_e;
    logic [31:0] exp_d, held_d;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin @(posedge clk); #1; waited++; end
    check_val({tag, ":issue_gap"}, 32'(waited), 32'd0);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    exp_e = pred_err(sz, ad);
    exp_d = (exp_e || wr) ? 32'd0 : pred_load(sz, sg, ad);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check_val({tag, ":busy"}, 32'(req_ready), 32'd0);
    if (!exp_e) check_val({tag, ":bus_addr"}, memory_address, ad);
    if (wr && !exp_e) check_val({tag, ":bus_wdata"}, memory_in, wd);
    we_cnt = memory_write_enable ? 1 : 0;
    edges = 0;
    while (resp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1; edges++;
      if (memory_write_enable) we_cnt++;
    end
    check_val({tag, ":latency"}, 32'(edges + 1), (exp_e || wr) ? 32'd2 : 32'(RL + 2));
    check_val({tag, ":we_cycles"}, 32'(we_cnt), (wr && !exp_e) ? 32'd1 : 32'd0);
    check_val({tag, ":error"}, 32'(resp_error), 32'(exp_e));
    check_val({tag, ":rdata"}, resp_rdata, exp_d);
    got_d = resp_rdata; got_e = resp_error; held_d = resp_rdata;
    if (wr && !exp_e)
      for (int i = 0; i < nbytes(sz); i++) ref_mem[8'(ad + 32'(i))] = wd[8*i +: 8];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
      check_val({tag, ":hold_rdata"}, resp_rdata, held_d);
      check_val({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_val({tag, ":done_valid"}, 32'(resp_valid), 32'd0);
    check_val({tag, ":done_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Overall time bound
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    logic [31:0] d;
    logic        e;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < LIMIT; i++) ref_mem[i] = 8'd0;
    @(posedge clk); #1; @(posedge clk); #1;
    check_idle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store/load round trip
    do_req("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, d, e);
    do_req("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, d, e);
    check_val("tp_ld_word", d, 32'hDEADBEEF);

    // Byte and half extension
    do_req("st_b20", 1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, 0, d, e);
    do_req("ld_bs20", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 0, d, e);
    check_val("tp_ld_byte_s", d, 32'hFFFFFF80);
    do_req("ld_bu20", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 0, d, e);
    check_val("tp_ld_byte_u", d, 32'h00000080);
    do_req("st_h20", 1'b1, 2'b01, 1'b0, 32'h20, 32'h00008001, 0, d, e);
    do_req("ld_hs20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 0, d, e);
    check_val("tp_ld_half_s", d, 32'hFFFF8001);

    // Range and size rejection, plus the last legal word
    do_req("ld_wfd", 1'b0, 2'b10, 1'b0, 32'hFD, 32'h0, 0, d, e);
    check_val("tp_oob_err", 32'(e), 32'd1);
    check_val("tp_oob_data", d, 32'd0);
    do_req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 0, d, e);
    check_val("tp_size3_err", 32'(e), 32'd1);
    do_req("ld_wfc", 1'b0, 2'b10, 1'b0, 32'hFC, 32'h0, 0, d, e);
    check_val("tp_last_word_err", 32'(e), 32'd0);
    do_req("st_bff", 1'b1, 2'b00, 1'b0, 32'hFF, 32'h5A, 0, d, e);
    check_val("tp_last_byte_err", 32'(e), 32'd0);
    do_req("st_hugeaddr", 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h5A, 0, d, e);
    check_val("tp_wrap_err", 32'(e), 32'd1);

    // Backpressure: response held for five cycles
    do_req("ld_hold", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, d, e);
    check_val("tp_hold_data", d, 32'hDEADBEEF);

    // Reset while waiting in READ
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("rd_abort:busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("rd_abort");
    @(posedge clk); #1;
    check_idle("rd_abort_after");

    // Reset during WRITE; data equals current contents so memory is unchanged
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40;
    req_wdata = pred_load(2'b10, 1'b0, 32'h40);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("wr_abort:we", 32'(memory_write_enable), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("wr_abort");

    // Reset on the accept edge of a store: nothing is written
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h50;
    req_wdata = 32'hCAFEF00D; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    check_idle("acc_abort");
    @(posedge clk); #1;
    check_idle("acc_abort_after");
    do_req("ld_w50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 0, d, e);
    check_val("tp_abort_mem", d, 32'h00000000);

    // Misaligned half store and load
    do_req("st_h31", 1'b1, 2'b01, 1'b0, 32'h31, 32'h00001234, 0, d, e);
`ifdef MISALIGN_CHECK_EN
    check_val("tp_misalign_err", 32'(e), 32'd1);
`else
    check_val("tp_misalign_err", 32'(e), 32'd0);
    do_req("ld_h31", 1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 0, d, e);
    check_val("tp_misalign_data", d, 32'h00001234);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 80; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, LIMIT + 7));
      do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ra, $urandom, $urandom_range(0, 3), d, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
